// File: rtl/ifu_fetch_datapath_pkg.sv
// Opcode constants shared by the IFU pre-decode and the IDU.
// Pure declarations: no latency, no backpressure.
package ifu_fetch_datapath_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    function automatic logic is_branch_opc(input logic [6:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/ifu_fetch_datapath_fifo_sync.sv
// Generic first-word-fall-through FIFO; head visible the cycle after push.
// Push is dropped when full, pop ignored when empty; a pop frees space only for the next cycle.
module fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_in_vld,
    input  logic [WIDTH-1:0]         i_in_dat,
    output logic                     o_out_vld,
    output logic [WIDTH-1:0]         o_out_dat,
    input  logic                     i_out_rdy,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push    = i_in_vld && (r_count != CW'(DEPTH));
    assign w_pop     = i_out_rdy && (r_count != '0);
    assign o_out_vld = (r_count != '0);
    assign o_out_dat = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_in_dat;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch_datapath.sv
// IFU fetch datapath: issues a bus read per accepted PC and pairs returned words with their PCs.
// Request is combinational with rx_fire; pair valid one cycle after response; rx_ready drops on buffer/credit exhaustion.
module ifu_fetch_datapath
    import ifu_fetch_datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_pc,
    output logic                  rx_ready,
    output logic                  bus_req_valid,
    output logic [DATA_WIDTH-1:0] bus_req_addr,
    input  logic                  bus_rsp_valid,
    input  logic [DATA_WIDTH-1:0] bus_rsp_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_pc,
    output logic [DATA_WIDTH-1:0] tx_inst,
    output logic [6:0]            tx_opcode,
    output logic                  tx_is_branch,
    input  logic                  tx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] w_pc_count;
    logic [CW-1:0] w_ib_count;
    logic [CW:0]   w_credit_used;
    logic          w_pc_vld;
    logic          w_ib_vld;
    logic          w_rx_fire;
    logic          w_rsp_accept;
    logic          w_tx_fire;

    // Credit covers words still on the bus plus words parked in inst_buf, so a response always has a slot.
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_ib_count};
    assign rx_ready      = (w_pc_count != CW'(DEPTH)) && (w_credit_used < (CW+1)'(DEPTH));
    assign w_rx_fire     = rx_valid && rx_ready;
    assign w_rsp_accept  = bus_rsp_valid && (r_outstanding != '0);

    assign bus_req_valid = w_rx_fire;
    assign bus_req_addr  = rx_pc;

    assign tx_valid      = w_pc_vld && w_ib_vld;
    assign w_tx_fire     = tx_valid && tx_ready;
    assign tx_opcode     = tx_inst[6:0];
    assign tx_is_branch  = tx_valid && is_branch_opc(tx_opcode);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rx_fire, w_rsp_accept})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    fifo_sync #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_pc_buf (
        .clk       (clk),
        .rstn      (rstn),
        .i_in_vld  (w_rx_fire),
        .i_in_dat  (rx_pc),
        .o_out_vld (w_pc_vld),
        .o_out_dat (tx_pc),
        .i_out_rdy (w_tx_fire),
        .o_count   (w_pc_count)
    );

    fifo_sync #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_inst_buf (
        .clk       (clk),
        .rstn      (rstn),
        .i_in_vld  (w_rsp_accept),
        .i_in_dat  (bus_rsp_data),
        .o_out_vld (w_ib_vld),
        .o_out_dat (tx_inst),
        .i_out_rdy (w_tx_fire),
        .o_count   (w_ib_count)
    );

endmodule

// File: tb/tb_ifu_fetch_datapath.sv
// Directed bench for ifu_fetch_datapath: hand-computed expectations checked with immediate assertions.
module tb_ifu_fetch_datapath;

    logic        clk;
    logic        rstn;
    logic        rx_valid;
    logic [31:0] rx_pc;
    logic        rx_ready;
    logic        bus_req_valid;
    logic [31:0] bus_req_addr;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_data;
    logic        tx_valid;
    logic [31:0] tx_pc;
    logic [31:0] tx_inst;
    logic [6:0]  tx_opcode;
    logic        tx_is_branch;
    logic        tx_ready;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_fetch_datapath #(.DATA_WIDTH(32), .DEPTH(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .rx_valid      (rx_valid),
        .rx_pc         (rx_pc),
        .rx_ready      (rx_ready),
        .bus_req_valid (bus_req_valid),
        .bus_req_addr  (bus_req_addr),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_data  (bus_rsp_data),
        .tx_valid      (tx_valid),
        .tx_pc         (tx_pc),
        .tx_inst       (tx_inst),
        .tx_opcode     (tx_opcode),
        .tx_is_branch  (tx_is_branch),
        .tx_ready      (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Distinct instruction word per PC so pairing errors show up.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h0000_0013 | (pc << 12);
    endfunction

    // Fetch one PC, respond next cycle, check the pair, then pop it.
    task automatic fetch_check(input logic [31:0] pc, input logic [31:0] inst,
                               input logic [6:0] exp_opc, input logic exp_br);
        cyc();
        rx_valid = 1'b1; rx_pc = pc;
        #1;
        chk("fc_req_vld", bus_req_valid, 1);
        chk("fc_req_addr", bus_req_addr, pc);
        cyc();
        rx_valid = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = inst;
        cyc();
        bus_rsp_valid = 1'b0;
        #1;
        chk("fc_tx_vld", tx_valid, 1);
        chk("fc_tx_pc", tx_pc, pc);
        chk("fc_tx_inst", tx_inst, inst);
        chk("fc_opcode", tx_opcode, exp_opc);
        chk("fc_is_branch", tx_is_branch, exp_br);
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        #1;
        chk("fc_drained", tx_valid, 0);
    endtask

    initial begin
        rstn = 1'b0; rx_valid = 1'b0; rx_pc = '0;
        bus_rsp_valid = 1'b0; bus_rsp_data = '0; tx_ready = 1'b0;
        cyc(); cyc();
        rstn = 1'b1;
        #1;
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_req_valid", bus_req_valid, 0);
        chk("rst_is_branch", tx_is_branch, 0);
        chk("rst_tx_pc", tx_pc, 0);
        chk("rst_tx_inst", tx_inst, 0);
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        #1;
        chk("empty_pop_ignored", tx_valid, 0);
        chk("empty_rx_ready", rx_ready, 1);

        // Single fetch, response two cycles after the request.
        cyc();
        rx_valid = 1'b1; rx_pc = 32'h0;
        #1;
        chk("sf_req_vld", bus_req_valid, 1);
        chk("sf_req_addr", bus_req_addr, 0);
        cyc();
        rx_valid = 1'b0;
        #1;
        chk("sf_no_req", bus_req_valid, 0);
        chk("sf_wait", tx_valid, 0);
        cyc();
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'h0000_0013;
        #1;
        chk("sf_rsp_cycle", tx_valid, 0);
        cyc();
        bus_rsp_valid = 1'b0;
        #1;
        chk("sf_tx_vld", tx_valid, 1);
        chk("sf_tx_pc", tx_pc, 0);
        chk("sf_tx_inst", tx_inst, 32'h13);
        chk("sf_is_branch", tx_is_branch, 0);
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        #1;
        chk("sf_drained", tx_valid, 0);

        // Branch detect.
        fetch_check(32'h40, 32'h0000_006F, 7'h6F, 1'b1);
        fetch_check(32'h44, 32'h0000_8067, 7'h67, 1'b1);
        fetch_check(32'h48, 32'h0000_0463, 7'h63, 1'b1);
        fetch_check(32'h4C, 32'h0000_0033, 7'h33, 1'b0);

        // Full: 8 PCs with responses, consumer stalled.
        for (int k = 0; k < 8; k++) begin
            cyc();
            rx_valid = 1'b1; rx_pc = 32'(4 * k);
            bus_rsp_valid = (k >= 1);
            bus_rsp_data  = inst_of(32'(4 * (k - 1)));
            #1;
            chk("full_rx_ready", rx_ready, 1);
            chk("full_req_addr", bus_req_addr, 32'(4 * k));
        end
        cyc();
        rx_pc = 32'h20; bus_rsp_valid = 1'b1; bus_rsp_data = inst_of(32'h1C);
        #1;
        chk("full_rx_blocked", rx_ready, 0);
        chk("full_no_req", bus_req_valid, 0);
        chk("full_hold_pc", tx_pc, 0);
        chk("full_hold_inst", tx_inst, inst_of(32'h0));
        cyc();
        bus_rsp_valid = 1'b0; tx_ready = 1'b1;
        #1;
        chk("full_pop_cycle_ready", rx_ready, 0);
        chk("full_pop_pc", tx_pc, 0);
        cyc();
        tx_ready = 1'b0; rx_valid = 1'b0;
        #1;
        chk("full_ready_after_pop", rx_ready, 1);
        for (int i = 1; i < 8; i++) begin
            tx_ready = 1'b1;
            #1;
            chk("full_drain_pc", tx_pc, 32'(4 * i));
            chk("full_drain_inst", tx_inst, inst_of(32'(4 * i)));
            cyc();
        end
        tx_ready = 1'b0;
        #1;
        chk("full_ninth_dropped", tx_valid, 0);

        // Outstanding limit: 8 requests, no responses yet.
        for (int k = 0; k < 8; k++) begin
            cyc();
            rx_valid = 1'b1; rx_pc = 32'(4 * k);
            #1;
            chk("os_rx_ready", rx_ready, 1);
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            rx_valid = 1'b0;
            bus_rsp_valid = 1'b1; bus_rsp_data = inst_of(32'(4 * k));
            #1;
            if (k == 0) begin
                chk("os_rx_blocked", rx_ready, 0);
                chk("os_tx_none", tx_valid, 0);
            end else begin
                chk("os_tx_head", tx_pc, 0);
            end
        end
        cyc();
        bus_rsp_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_ready = 1'b1;
            #1;
            chk("os_drain_pc", tx_pc, 32'(4 * i));
            chk("os_drain_inst", tx_inst, inst_of(32'(4 * i)));
            cyc();
        end
        tx_ready = 1'b0;
        #1;
        chk("os_empty", tx_valid, 0);

        // Back-to-back with 1-cycle response latency across pointer wrap.
        for (int k = 0; k < 22; k++) begin
            cyc();
            rx_valid = (k < 20);
            rx_pc = 32'h100 + 32'(4 * k);
            bus_rsp_valid = (k >= 1) && (k <= 20);
            bus_rsp_data  = inst_of(32'h100 + 32'(4 * (k - 1)));
            tx_ready = 1'b1;
            #1;
            if (k < 20) chk("b2b_rx_ready", rx_ready, 1);
            if (k >= 2) begin
                chk("b2b_tx_vld", tx_valid, 1);
                chk("b2b_tx_pc", tx_pc, 32'h100 + 32'(4 * (k - 2)));
                chk("b2b_tx_inst", tx_inst, inst_of(32'h100 + 32'(4 * (k - 2))));
            end else begin
                chk("b2b_fill", tx_valid, 0);
            end
        end
        cyc();
        rx_valid = 1'b0; bus_rsp_valid = 1'b0; tx_ready = 1'b0;
        #1;
        chk("b2b_empty", tx_valid, 0);

        // Reset with three pairs queued.
        for (int k = 0; k < 4; k++) begin
            cyc();
            rx_valid = (k < 3);
            rx_pc = 32'h200 + 32'(4 * k);
            bus_rsp_valid = (k >= 1);
            bus_rsp_data  = inst_of(32'h200 + 32'(4 * (k - 1)));
        end
        cyc();
        rx_valid = 1'b0; bus_rsp_valid = 1'b0;
        #1;
        chk("rs_queued", tx_valid, 1);
        chk("rs_head", tx_pc, 32'h200);
        rstn = 1'b0;
        #1;
        chk("rs_async_clear", tx_valid, 0);
        cyc();
        rstn = 1'b1;
        #1;
        chk("rs_tx_valid", tx_valid, 0);
        chk("rs_rx_ready", rx_ready, 1);
        chk("rs_tx_pc", tx_pc, 0);
        fetch_check(32'h300, 32'h0000_0463, 7'h63, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
